// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and helpers for the up/down counter
//
// Purpose:
//   Operating-mode and ONESHOT control-state enumerations shared by the
//   counter top level and its combinational step sub-module, plus a small
//   helper that classifies a raw mode code.
//
// Contents:
//   mode_e    - WRAP / SAT / ONESHOT (code 3 is unnamed and treated as WRAP)
//   state_e   - IDLE / RUN / DONE for the ONESHOT control FSM
//   holds_at_boundary() - 1 when a boundary step must hold the count
package counter_pkg;

  typedef enum logic [1:0] {
    WRAP    = 2'd0,
    SAT     = 2'd1,
    ONESHOT = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // SAT and ONESHOT both freeze the count on a boundary step; every other
  // code (WRAP and the unused code 3) rolls over.
  function automatic logic holds_at_boundary(input logic [1:0] mode);
    return (mode == SAT) || (mode == ONESHOT);
  endfunction

endpackage

// File: rtl/count_step.sv
// rtl/count_step.sv - combinational next-count calculation
//
// Purpose:
//   Given the current count, direction, bound and mode, computes the value
//   an enabled step would produce, and classifies the step.
//
// Ports:
//   out       in   WIDTH  current registered count
//   up        in   1      1 = increment, 0 = decrement
//   max_val   in   WIDTH  upper bound of the legal range 0..max_val
//   mode      in   2      raw mode code (see counter_pkg::mode_e)
//   next_val  out  WIDTH  count after an enabled step
//   boundary  out  1      step is at the edge of the range in its direction
//   clamp     out  1      count is above max_val; step pulls it back to max_val
module count_step
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] out,
  input  logic             up,
  input  logic [WIDTH-1:0] max_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_val,
  output logic             boundary,
  output logic             clamp
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic at_edge;

  // A count above max_val can only happen when max_val was lowered under a
  // running count. Clamping wins over the boundary classification so that
  // such a step never raises tc.
  assign clamp   = (out > max_val);
  assign at_edge = up ? (out == max_val) : (out == ZERO);

  always_comb begin
    next_val = out;
    boundary = 1'b0;
    if (clamp) begin
      next_val = max_val;
    end else if (at_edge) begin
      boundary = 1'b1;
      if (holds_at_boundary(mode)) begin
        next_val = out;
      end else begin
        next_val = up ? ZERO : max_val;
      end
    end else begin
      next_val = up ? (out + ONE) : (out - ONE);
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - bounded up/down counter with WRAP/SAT/ONESHOT
//
// Purpose:
//   Registered up/down counter over the range 0..max_val. WRAP rolls over at
//   the range edges, SAT holds there, ONESHOT runs once from a load until
//   the first boundary step and then parks. tc pulses for one cycle after
//   every boundary step.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous active-high reset
//   en        in   1      count enable, one step per edge
//   up        in   1      1 = increment, 0 = decrement
//   load      in   1      synchronous load strobe, has priority over en
//   load_val  in   WIDTH  load value, clipped to max_val
//   max_val   in   WIDTH  upper bound of the count
//   mode      in   2      0 WRAP, 1 SAT, 2 ONESHOT, 3 behaves as WRAP
//   out       out  WIDTH  registered count
//   tc        out  1      registered terminal-count pulse
//   busy      out  1      registered, ONESHOT run in progress
//   done      out  1      registered, ONESHOT run completed
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             tc_nxt;
  logic [WIDTH-1:0] step_val;
  logic             boundary;
  logic             clamp;
  logic [WIDTH-1:0] load_clip;

  count_step #(
    .WIDTH(WIDTH)
  ) u_count_step (
    .out      (out),
    .up       (up),
    .max_val  (max_val),
    .mode     (mode),
    .next_val (step_val),
    .boundary (boundary),
    .clamp    (clamp)
  );

  assign load_clip = (load_val > max_val) ? max_val : load_val;

  // Next-state and next-count logic. Outside ONESHOT the FSM is forced back
  // to IDLE while the count follows WRAP/SAT rules, so a mode switch never
  // disturbs out. Inside ONESHOT, en only acts in RUN.
  always_comb begin
    state_nxt = state;
    out_nxt   = out;
    tc_nxt    = 1'b0;

    if (mode != ONESHOT) begin
      state_nxt = IDLE;
      if (load) begin
        out_nxt = load_clip;
      end else if (en) begin
        out_nxt = step_val;
        tc_nxt  = boundary & ~clamp;
      end
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            out_nxt   = load_clip;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (load) begin
            out_nxt = load_clip;
          end else if (en) begin
            out_nxt = step_val;
            tc_nxt  = boundary & ~clamp;
            if (boundary & ~clamp) begin
              state_nxt = DONE;
            end
          end
        end
        DONE: begin
          if (load) begin
            out_nxt   = load_clip;
            state_nxt = RUN;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // busy/done are registered from the next state so they line up with the
  // state register and drop on the same edge that leaves ONESHOT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      out   <= '0;
      tc    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      out   <= out_nxt;
      tc    <= tc_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - directed vector bench for param_updown_counter
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] max_val;
  logic [1:0] mode;
  logic [3:0] out;
  logic       tc;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  param_updown_counter #(
    .WIDTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .max_val  (max_val),
    .mode     (mode),
    .out      (out),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] lv;
    logic [3:0] mx;
    logic [1:0] mode;
    logic [3:0] eo;
    logic       et;
    logic       eb;
    logic       ed;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic e, input logic u, input logic l,
                              input logic [3:0] lv, input logic [3:0] mx,
                              input logic [1:0] md, input logic [3:0] eo,
                              input logic et, input logic eb, input logic ed);
    vec_t v;
    v.en = e; v.up = u; v.load = l; v.lv = lv; v.mx = mx; v.mode = md;
    v.eo = eo; v.et = et; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eo, input logic et,
                         input logic eb, input logic ed);
    chk({tag, " out"}, 32'(out), 32'(eo));
    chk({tag, " tc"}, 32'(tc), 32'(et));
    chk({tag, " busy"}, 32'(busy), 32'(eb));
    chk({tag, " done"}, 32'(done), 32'(ed));
  endtask

  task automatic drive(input logic e, input logic u, input logic l,
                       input logic [3:0] lv, input logic [3:0] mx, input logic [1:0] md);
    en = e; up = u; load = l; load_val = lv; max_val = mx; mode = md;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    //           en up ld lv  mx  md  out tc busy done
    // WRAP down through zero
    vecs[0]  = mk(0, 0, 1, 2,  9,  0, 2,  0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0,  9,  0, 1,  0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0,  9,  0, 0,  0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0,  9,  0, 9,  1, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0,  9,  0, 8,  0, 0, 0);
    // SAT up into the ceiling
    vecs[5]  = mk(0, 1, 1, 10, 12, 1, 10, 0, 0, 0);
    vecs[6]  = mk(1, 1, 0, 0,  12, 1, 11, 0, 0, 0);
    vecs[7]  = mk(1, 1, 0, 0,  12, 1, 12, 0, 0, 0);
    vecs[8]  = mk(1, 1, 0, 0,  12, 1, 12, 1, 0, 0);
    vecs[9]  = mk(1, 1, 0, 0,  12, 1, 12, 1, 0, 0);
    vecs[10] = mk(0, 1, 0, 0,  12, 1, 12, 0, 0, 0);
    // ONESHOT down: IDLE ignores en, run, finish, reload
    vecs[11] = mk(1, 0, 0, 0,  15, 2, 12, 0, 0, 0);
    vecs[12] = mk(0, 0, 1, 3,  15, 2, 3,  0, 1, 0);
    vecs[13] = mk(1, 0, 0, 0,  15, 2, 2,  0, 1, 0);
    vecs[14] = mk(1, 0, 0, 0,  15, 2, 1,  0, 1, 0);
    vecs[15] = mk(1, 0, 0, 0,  15, 2, 0,  0, 1, 0);
    vecs[16] = mk(1, 0, 0, 0,  15, 2, 0,  1, 0, 1);
    vecs[17] = mk(1, 0, 0, 0,  15, 2, 0,  0, 0, 1);
    vecs[18] = mk(0, 0, 1, 5,  15, 2, 5,  0, 1, 0);
    // leaving ONESHOT drops busy without touching out
    vecs[19] = mk(0, 0, 0, 0,  15, 0, 5,  0, 0, 0);
    // load priority with clipping, then clamp, then wrap
    vecs[20] = mk(1, 1, 1, 14, 10, 0, 10, 0, 0, 0);
    vecs[21] = mk(1, 1, 0, 0,  4,  0, 4,  0, 0, 0);
    vecs[22] = mk(1, 1, 0, 0,  4,  0, 0,  1, 0, 0);
    // max_val == 0: every step is a boundary step
    vecs[23] = mk(1, 1, 0, 0,  0,  1, 0,  1, 0, 0);
    vecs[24] = mk(1, 0, 0, 0,  0,  1, 0,  1, 0, 0);
    // mode 3 behaves as WRAP
    vecs[25] = mk(0, 1, 1, 5,  5,  3, 5,  0, 0, 0);
    vecs[26] = mk(1, 1, 0, 0,  5,  3, 0,  1, 0, 0);
    vecs[27] = mk(1, 0, 0, 0,  5,  3, 5,  1, 0, 0);
    // SAT down holds at zero
    vecs[28] = mk(0, 0, 1, 0,  5,  1, 0,  0, 0, 0);
    vecs[29] = mk(1, 0, 0, 0,  5,  1, 0,  1, 0, 0);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk_all("reset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].lv, vecs[i].mx, vecs[i].mode);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].eo, vecs[i].et, vecs[i].eb, vecs[i].ed);
    end

    // Asynchronous reset mid-count, then counting resumes from zero
    drive(0, 1, 1, 0, 15, 0);
    tick();
    for (int k = 1; k <= 5; k++) begin
      drive(1, 1, 0, 0, 15, 0);
      tick();
      chk($sformatf("count%0d out", k), 32'(out), 32'(k));
    end
    #2;
    rst = 1'b1;
    #1;
    chk_all("async rst", 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    tick();
    chk("resume out", 32'(out), 32'd1);

    // Reset aborts a ONESHOT run sitting at its boundary; no tc follows
    drive(0, 0, 1, 2, 15, 2);
    tick();
    chk_all("os load", 2, 0, 1, 0);
    drive(1, 0, 0, 0, 15, 2);
    tick();
    tick();
    chk_all("os at zero", 0, 0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("os abort", 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    tick();
    chk_all("os idle after abort", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
